capture_buffer_ctrl: RTL and testbench

CAPTURE_BUFFER_CTRL -- requirements
Module: capture_buffer_ctrl

---
 rtl/capture_buffer_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_capture_buffer_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer_ctrl.sv
// Trigger-based capture controller: circular pre/post-trigger acquisition into a
// RAM, followed by read-out of one frame over a valid/ready stream.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for in_arm
// PRE       | collecting PRE_LEN pre-trigger samples, triggers ignored
// WAIT_TRIG | writing circularly until a trigger arrives
// POST      | collecting FRAME_LEN-PRE_LEN post-trigger samples
// READOUT   | streaming the frame from start_addr, writes suspended
module capture_buffer_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 405,
  parameter int PRE_LEN   = 100
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              fifo_enable,
  input  logic              in_mode,
  input  logic              in_arm,
  input  logic              in_sample_vld,
  input  logic [DATA_W-1:0] in_addata,
  input  logic              measure_sig,
  input  logic              in_force_trig,
  output logic [DATA_W-1:0] out_fifo_data,
  output logic              out_fifo_vld,
  input  logic              in_fifo_rdy,
  output logic              out_fifo_last,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_ovf
);

  localparam int POST_LEN = FRAME_LEN - PRE_LEN;
  localparam int CNT_W    = $clog2(FRAME_LEN + 1);
  localparam int DEPTH    = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, READOUT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              meas_q;
  logic              out_vld_q, out_vld_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  logic capturing, trig, wr_en, rd_en, accept, last_accept, pre_done, post_done;

  always_ff @(posedge in_clk) begin
    if (!in_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // post_done also fires in WAIT_TRIG when the trigger-cycle write is the only
  // post-trigger sample, so READOUT can follow the trigger directly.
  always_comb begin
    state_d = state_q;
    if (!fifo_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (in_arm)      state_d = PRE;
        PRE:       if (pre_done)    state_d = WAIT_TRIG;
        WAIT_TRIG: if (trig)        state_d = post_done ? READOUT : POST;
        POST:      if (post_done)   state_d = READOUT;
        READOUT:   if (last_accept) state_d = in_mode ? PRE : IDLE;
        default:                    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    capturing   = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);
    trig        = (meas_q & ~measure_sig) | in_force_trig;
    wr_en       = in_rst & fifo_enable & capturing & in_sample_vld;
    accept      = out_vld_q & in_fifo_rdy;
    last_accept = accept & out_last_q;
    rd_en       = in_rst & fifo_enable & (state_q == READOUT) &
                  (rd_cnt_q != CNT_W'(FRAME_LEN)) & (~out_vld_q | accept);
    pre_done    = wr_en & (smp_cnt_q == CNT_W'(PRE_LEN - 1));
    post_done   = wr_en & (smp_cnt_q == CNT_W'(POST_LEN - 1));
    out_busy    = (state_q != IDLE);
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    start_addr_d = start_addr_q;
    smp_cnt_d    = smp_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    out_vld_d    = out_vld_q;
    out_last_d   = out_last_q;
    ovf_d        = ovf_q;
    done_d       = last_accept;
    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    case (state_q)
      IDLE: begin
        smp_cnt_d = '0;
        if (in_arm && fifo_enable) ovf_d = 1'b0;
      end
      PRE: if (wr_en) smp_cnt_d = pre_done ? '0 : smp_cnt_q + CNT_W'(1);
      WAIT_TRIG: if (trig) begin
        start_addr_d = wr_ptr_q - ADDR_W'(PRE_LEN);
        rd_ptr_d     = wr_ptr_q - ADDR_W'(PRE_LEN);
        rd_cnt_d     = '0;
        smp_cnt_d    = wr_en ? CNT_W'(1) : '0;
      end
      POST: if (wr_en) smp_cnt_d = smp_cnt_q + CNT_W'(1);
      READOUT: begin
        smp_cnt_d = '0;
        if (in_sample_vld && fifo_enable) ovf_d = 1'b1;
        // The RAM output register doubles as the output holding register:
        // a new read is issued only when the current word leaves.
        if (rd_en) begin
          rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
          rd_cnt_d   = rd_cnt_q + CNT_W'(1);
          out_vld_d  = 1'b1;
          out_last_d = (rd_cnt_q == CNT_W'(FRAME_LEN - 1));
        end else if (accept) begin
          out_vld_d  = 1'b0;
          out_last_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (!fifo_enable) begin
      smp_cnt_d  = '0;
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      start_addr_q <= '0;
      smp_cnt_q    <= '0;
      rd_cnt_q     <= '0;
      meas_q       <= 1'b0;
      out_vld_q    <= 1'b0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      start_addr_q <= start_addr_d;
      smp_cnt_q    <= smp_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      meas_q       <= measure_sig;
      out_vld_q    <= out_vld_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge in_clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_addata;
    if (rd_en) ram_q <= mem[rd_ptr_q];
  end

  assign out_fifo_data = out_vld_q ? ram_q : '0;
  assign out_fifo_vld  = out_vld_q;
  assign out_fifo_last = out_last_q;
  assign out_done      = done_q;
  assign out_ovf       = ovf_q;

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Directed bench for capture_buffer_ctrl: expected frames are queued before each
// acquisition and a negedge monitor checks every word the read-out stream presents.
module tb_capture_buffer_ctrl;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int FRAME_LEN = 8;
  localparam int PRE_LEN   = 3;

  logic              in_clk, in_rst, fifo_enable, in_mode, in_arm;
  logic              in_sample_vld, measure_sig, in_force_trig, in_fifo_rdy;
  logic [DATA_W-1:0] in_addata, out_fifo_data;
  logic              out_fifo_vld, out_fifo_last, out_busy, out_done, out_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int first_acc = 0;
  int last_span = 0;
  int word_idx = 0;
  int rdy_mode = 0;
  int acc0 = 0;
  bit busy_watch = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] e;

  capture_buffer_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN), .PRE_LEN(PRE_LEN)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst), .fifo_enable(fifo_enable), .in_mode(in_mode),
    .in_arm(in_arm), .in_sample_vld(in_sample_vld), .in_addata(in_addata),
    .measure_sig(measure_sig), .in_force_trig(in_force_trig),
    .out_fifo_data(out_fifo_data), .out_fifo_vld(out_fifo_vld), .in_fifo_rdy(in_fifo_rdy),
    .out_fifo_last(out_fifo_last), .out_busy(out_busy), .out_done(out_done), .out_ovf(out_ovf)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] base);
    for (int i = 0; i < FRAME_LEN; i++)
      exp_q.push_back({(i == FRAME_LEN - 1), base + 8'(i)});
  endtask

  task automatic arm();
    in_arm = 1'b1;
    tick();
    in_arm = 1'b0;
  endtask

  // One sample per cycle; measure_sig low from fall_at on, force pulse at force_at.
  task automatic stream(input logic [7:0] base, input int n, input int fall_at, input int force_at);
    for (int j = 0; j < n; j++) begin
      in_sample_vld = 1'b1;
      in_addata     = base + 8'(j);
      measure_sig   = (fall_at >= 0 && j >= fall_at) ? 1'b0 : 1'b1;
      in_force_trig = (j == force_at);
      tick();
    end
    in_sample_vld = 1'b0;
    in_force_trig = 1'b0;
    measure_sig   = 1'b1;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 100) begin
      tick();
      n++;
    end
    check("done_count", done_cnt, target);
  endtask

  // Sink readiness: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = never ready.
  initial begin
    int bp = 0;
    in_fifo_rdy = 1'b1;
    forever begin
      @(posedge in_clk);
      #1;
      case (rdy_mode)
        0: in_fifo_rdy = 1'b1;
        1: begin
          in_fifo_rdy = (bp % 3 == 0);
          bp++;
        end
        default: in_fifo_rdy = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge in_clk);
      cyc++;
      if (out_done === 1'b1) done_cnt++;
      if (busy_watch) check("busy_continuous", out_busy, 1);
      if (out_fifo_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", out_fifo_vld, 0);
        end else if (in_fifo_rdy) begin
          e = exp_q.pop_front();
          check("word_data", out_fifo_data, e[7:0]);
          check("word_last", out_fifo_last, e[8]);
          if (word_idx == 0) first_acc = cyc;
          if (e[8]) begin
            last_span = cyc - first_acc;
            word_idx  = 0;
          end else begin
            word_idx++;
          end
          acc_cnt++;
        end else begin
          check("stall_data", out_fifo_data, exp_q[0][7:0]);
          check("stall_last", out_fifo_last, exp_q[0][8]);
        end
      end
    end
  end

  initial begin
    in_rst = 1'b0; fifo_enable = 1'b1; in_mode = 1'b0; in_arm = 1'b0;
    in_sample_vld = 1'b0; in_addata = '0; measure_sig = 1'b1; in_force_trig = 1'b0;
    repeat (3) tick();
    check("rst_busy", out_busy, 0);
    check("rst_vld", out_fifo_vld, 0);
    check("rst_last", out_fifo_last, 0);
    check("rst_done", out_done, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_data", out_fifo_data, 0);
    in_rst = 1'b1;
    tick();

    // basic single-shot: fall at wr_ptr=5 -> frame 0x02..0x09
    push_frame(8'h02);
    arm();
    check("arm_busy", out_busy, 1);
    stream(8'h00, 10, 5, -1);
    tick();
    tick();
    check("first_vld_latency", out_fifo_vld, 1);
    wait_done(1);
    check("t1_span", last_span, FRAME_LEN - 1);
    check("t1_idle", out_busy, 0);
    check("t1_ovf", out_ovf, 0);
    check("t1_empty", exp_q.size(), 0);

    // wrap-around: wr_ptr starts at 10, trigger at wr_ptr=1 -> start_addr 14
    push_frame(8'h44);
    arm();
    stream(8'h40, 12, 7, -1);
    wait_done(2);
    check("t2_idle", out_busy, 0);
    check("t2_empty", exp_q.size(), 0);

    // backpressure
    rdy_mode = 1;
    acc0 = acc_cnt;
    push_frame(8'h82);
    arm();
    stream(8'h80, 10, 5, -1);
    wait_done(3);
    check("bp_words", acc_cnt - acc0, FRAME_LEN);
    check("bp_empty", exp_q.size(), 0);
    rdy_mode = 0;

    // continuous mode: two force-triggered frames without re-arming
    in_mode = 1'b1;
    push_frame(8'hA1);
    arm();
    busy_watch = 1'b1;
    stream(8'hA0, 9, -1, 4);
    wait_done(4);
    push_frame(8'hC1);
    stream(8'hC0, 9, -1, 4);
    wait_done(5);
    busy_watch = 1'b0;
    check("cont_empty", exp_q.size(), 0);
    fifo_enable = 1'b0;
    tick();
    check("cont_disable_idle", out_busy, 0);
    fifo_enable = 1'b1;
    in_mode = 1'b0;

    // overflow: samples keep arriving during READOUT
    push_frame(8'h11);
    arm();
    stream(8'h10, 14, 4, -1);
    wait_done(6);
    check("ovf_set", out_ovf, 1);
    check("ovf_idle", out_busy, 0);

    // disable mid-POST: frame discarded, no output, no done
    arm();
    check("arm_clears_ovf", out_ovf, 0);
    stream(8'h30, 6, -1, 4);
    fifo_enable = 1'b0;
    in_sample_vld = 1'b1;
    in_addata = 8'h36;
    tick();
    check("dis_idle", out_busy, 0);
    check("dis_vld", out_fifo_vld, 0);
    fifo_enable = 1'b1;
    in_sample_vld = 1'b0;
    repeat (15) tick();
    check("dis_no_done", done_cnt, 6);

    // early trigger in PRE ignored; later fall at wr_ptr=7 -> frame 0x53..0x5A
    push_frame(8'h53);
    arm();
    stream(8'h50, 11, 6, 1);
    wait_done(7);
    check("early_empty", exp_q.size(), 0);

    // reset while a word is stalled in READOUT
    rdy_mode = 2;
    push_frame(8'h60);
    arm();
    stream(8'h60, 8, -1, 3);
    repeat (3) tick();
    check("stall_vld", out_fifo_vld, 1);
    in_rst = 1'b0;
    tick();
    check("rst_mid_vld", out_fifo_vld, 0);
    check("rst_mid_busy", out_busy, 0);
    check("rst_mid_done", out_done, 0);
    check("rst_mid_last", out_fifo_last, 0);
    exp_q.delete();
    in_rst = 1'b1;
    rdy_mode = 0;
    repeat (10) tick();
    check("rst_mid_no_done", done_cnt, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
